fpga_ram_sdp: RTL and testbench

FPGA_RAM_SDP -- requirements
Module: fpga_ram_sdp

---
 rtl/fpga_ram_pkg.sv | 14 +
 rtl/fpga_ram_clr_ctrl.sv | 49 ++++
 rtl/fpga_ram_sdp.sv | 156 +++++++++++++++
 tb/tb_fpga_ram_sdp.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_ram_pkg.sv
// Shared definitions for the simple-dual-port RAM: clear-sequence state encoding and word sizing.
package fpga_ram_pkg;

  typedef enum logic [1:0] {
    ClrIdle  = 2'd0,
    ClrClear = 2'd1,
    ClrDone  = 2'd2
  } clr_state_e;

  function automatic int unsigned bytes_per_word(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/fpga_ram_clr_ctrl.sv
// Power-on/reset clear sequencer: sweeps every address once with zero data while busy.
module fpga_ram_clr_ctrl
  import fpga_ram_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 busy_o,
  output logic                 clr_we_o,
  output logic [ADDRWIDTH-1:0] clr_addr_o
);

  clr_state_e           state_q, state_d;
  logic [ADDRWIDTH-1:0] cnt_q, cnt_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ClrClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {ADDRWIDTH{1'b1}}) state_d = ClrDone;
      end
      ClrDone: state_d = ClrIdle;
      default: state_d = state_q;
    endcase
    busy_d = (state_d == ClrClear);
  end

  // Reset (re)starts the sweep from address 0, including a reset that lands mid-clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ClrClear;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign clr_we_o   = busy_q;
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/fpga_ram_sdp.sv
// Simple-dual-port block RAM with byte enables, 1/2-cycle read latency and collision merge.
// Optional zeroing sequence after reset is enabled by defining FPGA_RAM_SDP_CLEAR_EN.
module fpga_ram_sdp
  import fpga_ram_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned ADDRWIDTH = 10,
  parameter int unsigned RDLATENCY = 1,
  parameter int unsigned BYPASS    = 1
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   WrEn,
  input  logic [ADDRWIDTH-1:0]   WrAddr,
  input  logic [DATAWIDTH/8-1:0] WrByteEn,
  input  logic [DATAWIDTH-1:0]   WrData,
  input  logic                   RdEn,
  input  logic [ADDRWIDTH-1:0]   RdAddr,
  output logic [DATAWIDTH-1:0]   RdData,
  output logic                   RdValid,
  output logic                   InitBusy
);

  localparam int unsigned NBYTES   = bytes_per_word(DATAWIDTH);
  localparam int unsigned MEMDEPTH = 1 << ADDRWIDTH;

  logic                 busy;
  logic                 mem_we;
  logic [ADDRWIDTH-1:0] mem_addr;
  logic [NBYTES-1:0]    mem_be;
  logic [DATAWIDTH-1:0] mem_wd;

`ifdef FPGA_RAM_SDP_CLEAR_EN
  logic                 clr_we;
  logic [ADDRWIDTH-1:0] clr_addr;

  fpga_ram_clr_ctrl #(
    .ADDRWIDTH(ADDRWIDTH)
  ) u_clr_ctrl (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .busy_o    (busy),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr)
  );

  // The sweep owns the write port while busy; user writes are dropped.
  always_comb begin
    mem_we   = WrEn;
    mem_addr = WrAddr;
    mem_be   = WrByteEn;
    mem_wd   = WrData;
    if (busy) begin
      mem_we   = clr_we;
      mem_addr = clr_addr;
      mem_be   = '1;
      mem_wd   = '0;
    end
  end
`else
  assign busy     = 1'b0;
  assign mem_we   = WrEn;
  assign mem_addr = WrAddr;
  assign mem_be   = WrByteEn;
  assign mem_wd   = WrData;
`endif

  assign InitBusy = busy;

  logic                 rd_fire;
  logic                 col_hit;
  logic [DATAWIDTH-1:0] mem [MEMDEPTH];
  logic [DATAWIDTH-1:0] arr_q;

  assign rd_fire = RdEn & ~busy;
  assign col_hit = mem_we & (mem_addr == RdAddr) & (BYPASS != 0);

  // Plain read-first array template so the tools map it onto block RAM.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wd[8*i +: 8];
      end
    end
    if (rd_fire) arr_q <= mem[RdAddr];
  end

  logic                 p1_valid_q, p1_valid_d;
  logic                 col_q, col_d;
  logic [NBYTES-1:0]    col_be_q, col_be_d;
  logic [DATAWIDTH-1:0] col_data_q, col_data_d;
  logic [DATAWIDTH-1:0] col_mask;
  logic [DATAWIDTH-1:0] merged;

  always_comb begin
    p1_valid_d = rd_fire;
    col_d      = rd_fire ? col_hit  : col_q;
    col_be_d   = rd_fire ? mem_be   : col_be_q;
    col_data_d = rd_fire ? mem_wd   : col_data_q;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      p1_valid_q <= 1'b0;
      col_q      <= 1'b0;
      col_be_q   <= '0;
      col_data_q <= '0;
    end else begin
      p1_valid_q <= p1_valid_d;
      col_q      <= col_d;
      col_be_q   <= col_be_d;
      col_data_q <= col_data_d;
    end
  end

  // Write-first collisions patch the captured old word with the bytes written that cycle.
  always_comb begin
    col_mask = '0;
    for (int i = 0; i < NBYTES; i++) col_mask[8*i +: 8] = {8{col_be_q[i]}};
    merged = col_q ? ((arr_q & ~col_mask) | (col_data_q & col_mask)) : arr_q;
  end

  if (RDLATENCY == 2) begin : g_lat2
    logic                 p2_valid_q;
    logic [DATAWIDTH-1:0] rd_data_q, rd_data_d;

    always_comb rd_data_d = p1_valid_q ? merged : rd_data_q;

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        p2_valid_q <= 1'b0;
        rd_data_q  <= '0;
      end else begin
        p2_valid_q <= p1_valid_q;
        rd_data_q  <= rd_data_d;
      end
    end

    assign RdValid = p2_valid_q;
    assign RdData  = rd_data_q;
  end else begin : g_lat1
    // The array register has no reset, so blank the output until the first read lands.
    logic blank_q, blank_d;

    always_comb blank_d = blank_q & ~rd_fire;

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) blank_q <= 1'b1;
      else     blank_q <= blank_d;
    end

    assign RdValid = p1_valid_q;
    assign RdData  = blank_q ? '0 : merged;
  end

endmodule

// File: tb/tb_fpga_ram_sdp.sv
// Self-checking bench: a write-first/latency-1 and a read-first/latency-2 RAM driven in lockstep.
module tb_fpga_ram_sdp;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
`ifdef FPGA_RAM_SDP_CLEAR_EN
  localparam bit ClrEn = 1'b1;
`else
  localparam bit ClrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        we, re;
  logic [3:0]  wa, ra, be;
  logic [31:0] wd;
  logic [31:0] rd1, rd2;
  logic        v1, v2, b1, b2;

  always #5 clk = ~clk;

  fpga_ram_sdp #(
    .DATAWIDTH(32), .ADDRWIDTH(AW), .RDLATENCY(1), .BYPASS(1)
  ) u_dut_wf (
    .Clk(clk), .Rst(rst), .WrEn(we), .WrAddr(wa), .WrByteEn(be), .WrData(wd),
    .RdEn(re), .RdAddr(ra), .RdData(rd1), .RdValid(v1), .InitBusy(b1)
  );

  fpga_ram_sdp #(
    .DATAWIDTH(32), .ADDRWIDTH(AW), .RDLATENCY(2), .BYPASS(0)
  ) u_dut_rf (
    .Clk(clk), .Rst(rst), .WrEn(we), .WrAddr(wa), .WrByteEn(be), .WrData(wd),
    .RdEn(re), .RdAddr(ra), .RdData(rd2), .RdValid(v2), .InitBusy(b2)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        re;
    logic [3:0]  ra;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  rd_t         q1[$], q2[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last1, last2;
  int          busy_left, cyc, checks, errors;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] b);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{b[i]}};
    return m;
  endfunction

  task automatic check_outs();
    rd_t e;
    logic e1, e2, eb;
    e1 = (q1.size() > 0) && (q1[0].due == cyc);
    e2 = (q2.size() > 0) && (q2[0].due == cyc);
    if (e1) begin e = q1.pop_front(); last1 = e.data; end
    if (e2) begin e = q2.pop_front(); last2 = e.data; end
    eb = ClrEn && (rst || busy_left > 0);
    chk("valid_wf", 32'(v1), 32'(e1));
    chk("data_wf", rd1, last1);
    chk("valid_rf", 32'(v2), 32'(e2));
    chk("data_rf", rd2, last2);
    chk("busy_wf", 32'(b1), 32'(eb));
    chk("busy_rf", 32'(b2), 32'(eb));
  endtask

  // One clock: model consumes the inputs sampled at this edge, then outputs are compared.
  task automatic tick();
    logic [31:0] old, nw, m;
    rd_t e;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      if (busy_left > 0) busy_left--;
      else begin
        m = be_mask(be);
        if (re) begin
          old = mem_m[ra];
          nw  = (we && wa == ra) ? ((old & ~m) | (wd & m)) : old;
          e.due = cyc;     e.data = nw;  q1.push_back(e);
          e.due = cyc + 1; e.data = old; q2.push_back(e);
        end
        if (we) mem_m[wa] = (mem_m[wa] & ~m) | (wd & m);
      end
    end
    #1;
    check_outs();
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    idle();
    rst = 1'b1;
    q1.delete(); q2.delete();
    last1 = '0; last2 = '0;
`ifdef FPGA_RAM_SDP_CLEAR_EN
    busy_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
`endif
    #1;
    check_outs();
    repeat (hold) tick();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; be = 4'hF; wd = d; re = 1'b0;
    tick();
    idle();
  endtask

  vec_t        tbl[9];
  logic        p2;
  logic [31:0] e2p;
  logic [5:0]  pat1, pat2;
  int          n;

  initial begin
    rst = 1'b0; we = 1'b0; re = 1'b0; wa = '0; ra = '0; be = '0; wd = '0;
    cyc = 0; checks = 0; errors = 0; busy_left = 0; last1 = '0; last2 = '0;

    do_reset(3);
    n = 0;
    while (busy_left > 0 && n < 40) begin tick(); n++; end
    for (int i = 0; i < DEPTH; i++) wr(4'(i), 32'hA5A5A5A5);

    // Directed vectors: expected read data for each DUT written out by hand.
    tbl[0] = '{1'b1, 4'd5, 4'hF,    32'hAABBCCDD, 1'b0, 4'd0, 32'h0,        32'h0};
    tbl[1] = '{1'b1, 4'd5, 4'b0101, 32'h11223344, 1'b0, 4'd0, 32'h0,        32'h0};
    tbl[2] = '{1'b1, 4'd3, 4'hF,    32'h00000000, 1'b1, 4'd5, 32'hAA22CC44, 32'hAA22CC44};
    tbl[3] = '{1'b1, 4'd3, 4'hF,    32'hFFFFFFFF, 1'b1, 4'd3, 32'hFFFFFFFF, 32'h00000000};
    tbl[4] = '{1'b0, 4'd0, 4'h0,    32'h0,        1'b1, 4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[5] = '{1'b1, 4'd7, 4'h0,    32'h12345678, 1'b1, 4'd5, 32'hAA22CC44, 32'hAA22CC44};
    tbl[6] = '{1'b0, 4'd0, 4'h0,    32'h0,        1'b1, 4'd7, 32'hA5A5A5A5, 32'hA5A5A5A5};
    tbl[7] = '{1'b1, 4'd9, 4'b1000, 32'hDEAD0000, 1'b1, 4'd9, 32'hDEA5A5A5, 32'hA5A5A5A5};
    tbl[8] = '{1'b0, 4'd0, 4'h0,    32'h0,        1'b1, 4'd9, 32'hDEA5A5A5, 32'hDEA5A5A5};
    p2 = 1'b0; e2p = '0;
    for (int i = 0; i < 9; i++) begin
      we = tbl[i].we; wa = tbl[i].wa; be = tbl[i].be; wd = tbl[i].wd;
      re = tbl[i].re; ra = tbl[i].ra;
      tick();
      if (tbl[i].re) chk($sformatf("tbl%0d_wf", i), rd1, tbl[i].exp1);
      if (p2) chk($sformatf("tbl%0d_rf", i - 1), rd2, e2p);
      p2 = tbl[i].re; e2p = tbl[i].exp2;
    end
    idle();
    tick();
    if (p2) chk("tbl8_rf", rd2, e2p);

    // Back-to-back reads: no bubbles, valid shifted by the latency.
    for (int i = 0; i < 4; i++) wr(4'(i), 32'h10000000 + i);
    for (int i = 0; i < 6; i++) begin
      we = 1'b0; re = (i < 4); ra = 4'(i);
      tick();
      pat1[i] = v1; pat2[i] = v2;
    end
    idle();
    chk("lat1_pattern", 32'(pat1), 32'h0F);
    chk("lat2_pattern", 32'(pat2), 32'h1E);

    // Random traffic with frequent same-address collisions.
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
      be = 4'($urandom);
      wd = $urandom;
      tick();
    end
    idle();
    tick();

    // Reset one cycle after a read request: the latency-2 result must never appear.
    re = 1'b1; ra = 4'd2;
    tick();
    do_reset(2);
    chk("rst_data_rf", rd2, 32'h0);
    n = 0;
    for (int i = 0; i < 5; i++) begin tick(); n += int'(v1) + int'(v2); end
    chk("no_pulse_after_rst", 32'(n), 32'h0);
    n = 0;
    while (busy_left > 0 && n < 40) begin tick(); n++; end

`ifdef FPGA_RAM_SDP_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) wr(4'(i), 32'hA5A5A5A5);
    do_reset(2);
    n = int'(b1);
    for (int i = 0; i < 20; i++) begin
      we = (i < 16); re = (i < 16); wa = 4'(i); ra = 4'(i); be = 4'hF; wd = $urandom;
      tick();
      n += int'(b1);
    end
    idle();
    chk("clear_busy_len", 32'(n), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      re = 1'b1; ra = 4'(i);
      tick();
      chk($sformatf("clear_rd%0d", i), rd1, 32'h0);
    end
    idle();
    tick();

    do_reset(1);
    repeat (7) tick();
    do_reset(1);
    n = int'(b1);
    for (int i = 0; i < 20; i++) begin tick(); n += int'(b1); end
    chk("restart_busy_len", 32'(n), 32'd16);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
